fx_div: RTL and testbench

FX_DIV -- requirements
Module: fx_div

---
 rtl/fx_pkg.sv | 20 ++
 rtl/fx_div_if.sv | 28 ++
 rtl/fx_sat_pack.sv | 51 +++++
 rtl/fx_div.sv | 161 ++++++++++++++++
 tb/tb_fx_div.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fx_pkg.sv
// Shared constants for the fixed-point datapath (divider and multiplier paths).
// Holds the default Q format (QP.F), the divider iteration count, the
// saturation limits and the divider state encoding.
package fx_pkg;

    localparam int unsigned FX_F = 10;                    // fractional bits
    localparam int unsigned FX_P = 5;                     // integer bits
    localparam int unsigned FX_W = FX_F + FX_P + 1;       // total signed width
    localparam int unsigned FX_N = FX_W - 1 + FX_F;       // quotient bits / divide steps

    localparam logic [FX_W-1:0] Q_MAX = {1'b0, {(FX_W-1){1'b1}}};
    localparam logic [FX_W-1:0] Q_MIN = {1'b1, {(FX_W-1){1'b0}}};

    // Divider state encoding
    typedef logic [1:0] fx_state_t;
    localparam fx_state_t ST_IDLE = 2'd0;
    localparam fx_state_t ST_CALC = 2'd1;
    localparam fx_state_t ST_FIN  = 2'd2;

endpackage

// File: rtl/fx_div_if.sv
// Request/response bundle of the fixed-point divider.
//   start     : request pulse (master -> slave)
//   A, B      : signed QP.F dividend / divisor (master -> slave)
//   busy      : divider not idle (slave -> master)
//   valid     : one-cycle result strobe (slave -> master)
//   Y, sat, dz: quotient, clamp flag, divide-by-zero flag (slave -> master)
interface fx_div_if #(
    parameter int unsigned W = fx_pkg::FX_W
);
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         valid;
    logic [W-1:0] Y;
    logic         sat;
    logic         dz;

    modport master (
        output start, A, B,
        input  busy, valid, Y, sat, dz
    );

    modport slave (
        input  start, A, B,
        output busy, valid, Y, sat, dz
    );
endinterface

// File: rtl/fx_sat_pack.sv
// Applies a result sign to an unsigned magnitude and clamps it to the signed
// W-bit range. Purely combinational; shared by the divide and multiply paths.
//   mag_i : unsigned result magnitude (MW bits, MW >= W)
//   neg_i : result is negative
//   dz_i  : divisor was zero; any nonzero magnitude then means "infinite"
//   y_o   : signed W-bit result
//   sat_o : result was clamped
module fx_sat_pack
    import fx_pkg::*;
#(
    parameter int unsigned W  = FX_W,
    parameter int unsigned MW = FX_N + 1
) (
    input  logic [MW-1:0] mag_i,
    input  logic          neg_i,
    input  logic          dz_i,
    output logic [W-1:0]  y_o,
    output logic          sat_o
);
    localparam logic [W-1:0]  Y_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  Y_MIN   = {1'b1, {(W-1){1'b0}}};
    localparam logic [MW-1:0] MAG_POS = MW'(Y_MAX);
    localparam logic [MW-1:0] MAG_NEG = MW'(Y_MIN);

    // Negative results may reach one step further than positive ones
    always_comb begin
        y_o   = '0;
        sat_o = 1'b0;
        if (dz_i) begin
            if (mag_i != '0) begin
                sat_o = 1'b1;
                y_o   = neg_i ? Y_MIN : Y_MAX;
            end
        end else if (!neg_i) begin
            if (mag_i > MAG_POS) begin
                sat_o = 1'b1;
                y_o   = Y_MAX;
            end else begin
                y_o = mag_i[W-1:0];
            end
        end else begin
            if (mag_i > MAG_NEG) begin
                sat_o = 1'b1;
                y_o   = Y_MIN;
            end else begin
                y_o = W'('0) - mag_i[W-1:0];
            end
        end
    end

endmodule

// File: rtl/fx_div.sv
// Sequential signed fixed-point divider, Y = A / B in QP.F, truncated toward
// zero and saturated. One restoring-division step per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fx_div_if slave (start/A/B in; busy/valid/Y/sat/dz out)
module fx_div
    import fx_pkg::*;
#(
    parameter int unsigned F = FX_F,
    parameter int unsigned P = FX_P,
    parameter int unsigned W = F + P + 1
) (
    input  logic    clk,
    input  logic    rst_n,
    fx_div_if.slave bus
);
    localparam int unsigned N  = W - 1 + F;     // quotient bits / steps
    localparam int unsigned RW = W + F;         // remainder width
    localparam int unsigned DW = RW + 2;        // subtractor width incl. borrow
    localparam int unsigned CW = $clog2(N);     // step counter width
    localparam int unsigned MW = N + 1;         // magnitude incl. overflow bit

    fx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [W-1:0]  bmag_q, bmag_d;
    logic          neg_q, neg_d;
    logic          ovf_q, ovf_d;
    logic          dz_q, dz_d;
    logic [W-1:0]  y_q, y_d;
    logic          sat_q, sat_d;
    logic          dzo_q, dzo_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;

    logic [W-1:0]  a_mag_c;
    logic [W-1:0]  b_mag_c;
    logic [RW:0]   rem_sh_c;
    logic [DW-1:0] diff_c;
    logic          ge_c;
    logic [W-1:0]  y_c;
    logic          sat_c;

    // Magnitudes; W unsigned bits so the most negative input is representable
    assign a_mag_c = bus.A[W-1] ? W'(-bus.A) : bus.A;
    assign b_mag_c = bus.B[W-1] ? W'(-bus.B) : bus.B;

    // Quotient register doubles as the dividend shifter: its MSB feeds the
    // remainder while the new quotient bit enters at the LSB.
    assign rem_sh_c = {rem_q, quo_q[N-1]};
    assign diff_c   = {1'b0, rem_sh_c} - DW'(bmag_q);
    assign ge_c     = ~diff_c[DW-1];

    // Sign application and clamping of the finished magnitude
    fx_sat_pack #(
        .W  (W),
        .MW (MW)
    ) u_sat (
        .mag_i ({ovf_q, quo_q}),
        .neg_i (neg_q),
        .dz_i  (dz_q),
        .y_o   (y_c),
        .sat_o (sat_c)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            bmag_q  <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            y_q     <= '0;
            sat_q   <= 1'b0;
            dzo_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            bmag_q  <= bmag_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
            y_q     <= y_d;
            sat_q   <= sat_d;
            dzo_q   <= dzo_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        bmag_d  = bmag_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        y_d     = y_q;
        sat_d   = sat_q;
        dzo_d   = dzo_q;
        valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    bmag_d = b_mag_c;
                    neg_d  = bus.A[W-1] ^ bus.B[W-1];
                    dz_d   = (bus.B == '0);
                    // Dividend top bit is only set for |A| = 2^(W-1); it seeds
                    // the remainder, and with |B| <= 1 the quotient overflows
                    // the N-bit register (saturation is certain then).
                    rem_d  = RW'(a_mag_c[W-1]);
                    quo_d  = {a_mag_c[W-2:0], {F{1'b0}}};
                    ovf_d  = a_mag_c[W-1] & (b_mag_c <= W'(1));
                    cnt_d  = CW'(N - 1);
                    state_d = (bus.B == '0) ? ST_FIN : ST_CALC;
                end
            end
            ST_CALC: begin
                rem_d = ge_c ? RW'(diff_c) : RW'(rem_sh_c);
                quo_d = {quo_q[N-2:0], ge_c};
                if (cnt_q == '0) begin
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_FIN: begin
                y_d     = y_c;
                sat_d   = sat_c;
                dzo_d   = dz_q;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.Y     = y_q;
    assign bus.sat   = sat_q;
    assign bus.dz    = dzo_q;

endmodule

// File: tb/tb_fx_div.sv
// Self-checking bench for fx_div at the default Q5.10 format.
module tb_fx_div;
    import fx_pkg::*;

    localparam int unsigned W = FX_W;
    localparam int LAT    = FX_N + 2;   // edges from start sampling to valid
    localparam int LAT_DZ = 2;
    localparam int BUDGET = 200;

    typedef struct packed {
        logic [W-1:0] y;
        logic         sat;
        logic         dz;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    res_t exp_q[$];
    res_t obs_q[$];
    int   obs_cyc[$];

    fx_div_if #(.W(W)) bus();

    fx_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every result strobe together with the edge that produced it
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            obs_q.push_back(res_t'{bus.Y, bus.sat, bus.dz});
            obs_cyc.push_back(cyc);
        end
    end

    // Reference: exact integer division, truncated toward zero, then clamped
    function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b);
        longint sa, sb, ma, mb, q, lim;
        res_t   r;
        bit     neg;
        r   = '0;
        lim = longint'(1) <<< (W - 1);
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        if (sb == 0) begin
            r.dz = 1'b1;
            if (sa > 0) begin r.y = W'(lim - 1); r.sat = 1'b1; end
            else if (sa < 0) begin r.y = W'(lim); r.sat = 1'b1; end
        end else begin
            ma  = (sa < 0) ? -sa : sa;
            mb  = (sb < 0) ? -sb : sb;
            q   = (ma <<< FX_F) / mb;
            neg = (sa < 0) != (sb < 0);
            if (!neg) begin
                if (q > lim - 1) begin r.y = W'(lim - 1); r.sat = 1'b1; end
                else r.y = W'(q);
            end else begin
                if (q > lim) begin r.y = W'(lim); r.sat = 1'b1; end
                else r.y = W'(-q);
            end
        end
        return r;
    endfunction

    // Present one request for a single cycle, then scramble the operands
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output int icyc);
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        icyc      = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
    endtask

    // Wait (bounded) for the next captured result
    task automatic collect(output res_t r, output int vcyc, output bit got);
        int n = 0;
        r = '0; vcyc = 0; got = 1'b0;
        while (obs_q.size() == 0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (obs_q.size() != 0) begin
            r    = obs_q.pop_front();
            vcyc = obs_cyc.pop_front();
            got  = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        checks++; if (bus.Y !== '0)       begin errors++; $display("FAIL reset_y: got %h want 0", bus.Y); end
        checks++; if (bus.sat !== 1'b0)   begin errors++; $display("FAIL reset_sat: got %b want 0", bus.sat); end
        checks++; if (bus.dz !== 1'b0)    begin errors++; $display("FAIL reset_dz: got %b want 0", bus.dz); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", bus.valid); end
    endtask

    task automatic test_basic();
        logic [W-1:0] va [4] = '{16'h0C00, 16'hF400, 16'h0400, 16'hFC00};
        logic [W-1:0] vb [4] = '{16'h0800, 16'h0800, 16'h0C00, 16'h0C00};
        logic [W-1:0] vy [4] = '{16'h0600, 16'hFA00, 16'h0155, 16'hFEAB};
        res_t r, e;
        int   icyc, vcyc;
        bit   got;
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i], icyc);
            exp_q.push_back(res_t'{vy[i], 1'b0, 1'b0});
            checks++;
            if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy[%0d]: got %b want 1", i, bus.busy); end
            collect(r, vcyc, got);
            e = exp_q.pop_front();
            checks++;
            if (!got) begin errors++; $display("FAIL basic_timeout[%0d]: no valid within %0d cycles", i, BUDGET); end
            else begin
                if (r !== e) begin errors++; $display("FAIL basic[%0d]: got y=%h sat=%b dz=%b want y=%h sat=%b dz=%b", i, r.y, r.sat, r.dz, e.y, e.sat, e.dz); end
                checks++;
                if (vcyc - icyc !== LAT) begin errors++; $display("FAIL basic_lat[%0d]: got %0d want %0d", i, vcyc - icyc, LAT); end
            end
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] va [3] = '{16'h4000, 16'hC000, 16'h8000};
        logic [W-1:0] vb [3] = '{16'h0100, 16'h0100, 16'h0400};
        logic [W-1:0] vy [3] = '{16'h7FFF, 16'h8000, 16'h8000};
        logic         vs [3] = '{1'b1, 1'b1, 1'b0};
        res_t r, e;
        int   icyc, vcyc;
        bit   got;
        for (int i = 0; i < 3; i++) begin
            issue(va[i], vb[i], icyc);
            exp_q.push_back(res_t'{vy[i], vs[i], 1'b0});
            collect(r, vcyc, got);
            e = exp_q.pop_front();
            checks++;
            if (!got) begin errors++; $display("FAIL sat_timeout[%0d]: no valid within %0d cycles", i, BUDGET); end
            else begin
                if (r !== e) begin errors++; $display("FAIL sat[%0d]: got y=%h sat=%b dz=%b want y=%h sat=%b dz=%b", i, r.y, r.sat, r.dz, e.y, e.sat, e.dz); end
                checks++;
                if (vcyc - icyc !== LAT) begin errors++; $display("FAIL sat_lat[%0d]: got %0d want %0d", i, vcyc - icyc, LAT); end
            end
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] va [3] = '{16'h1400, 16'hEC00, 16'h0000};
        logic [W-1:0] vy [3] = '{16'h7FFF, 16'h8000, 16'h0000};
        logic         vs [3] = '{1'b1, 1'b1, 1'b0};
        res_t r, e;
        int   icyc, vcyc;
        bit   got;
        for (int i = 0; i < 3; i++) begin
            issue(va[i], 16'h0000, icyc);
            exp_q.push_back(res_t'{vy[i], vs[i], 1'b1});
            collect(r, vcyc, got);
            e = exp_q.pop_front();
            checks++;
            if (!got) begin errors++; $display("FAIL dz_timeout[%0d]: no valid within %0d cycles", i, BUDGET); end
            else begin
                if (r !== e) begin errors++; $display("FAIL dz[%0d]: got y=%h sat=%b dz=%b want y=%h sat=%b dz=%b", i, r.y, r.sat, r.dz, e.y, e.sat, e.dz); end
                checks++;
                if (vcyc - icyc !== LAT_DZ) begin errors++; $display("FAIL dz_lat[%0d]: got %0d want %0d", i, vcyc - icyc, LAT_DZ); end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] fa [5] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h0001, 16'h8000};
        logic [W-1:0] fb [5] = '{16'h0001, 16'hFFFF, 16'h0001, 16'h7FFF, 16'h8000};
        logic [W-1:0] a, b;
        res_t r, e;
        int   icyc, vcyc, lat;
        bit   got;
        for (int i = 0; i < 29; i++) begin
            if (i < 5) begin a = fa[i]; b = fb[i]; end
            else begin
                a = W'($urandom);
                b = (i % 8 == 0) ? '0 : W'($urandom);
                if (i % 3 == 0) b = W'($signed(b) >>> 6);
            end
            issue(a, b, icyc);
            exp_q.push_back(model(a, b));
            lat = (b == '0) ? LAT_DZ : LAT;
            collect(r, vcyc, got);
            e = exp_q.pop_front();
            checks++;
            if (!got) begin errors++; $display("FAIL rand_timeout[%0d]: no valid within %0d cycles", i, BUDGET); end
            else begin
                if (r !== e) begin errors++; $display("FAIL rand[%0d] a=%h b=%h: got y=%h sat=%b dz=%b want y=%h sat=%b dz=%b", i, a, b, r.y, r.sat, r.dz, e.y, e.sat, e.dz); end
                checks++;
                if (vcyc - icyc !== lat) begin errors++; $display("FAIL rand_lat[%0d]: got %0d want %0d", i, vcyc - icyc, lat); end
            end
        end
    endtask

    task automatic test_busy_ignore();
        res_t r, e;
        int   icyc, vcyc;
        bit   got;
        issue(16'h0C00, 16'h0800, icyc);
        exp_q.push_back(res_t'{16'h0600, 1'b0, 1'b0});
        repeat (8) @(negedge clk);
        bus.A     = 16'h0400;
        bus.B     = 16'h0C00;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        collect(r, vcyc, got);
        e = exp_q.pop_front();
        checks++;
        if (!got) begin errors++; $display("FAIL ignore_timeout: no valid within %0d cycles", BUDGET); end
        else begin
            if (r !== e) begin errors++; $display("FAIL ignore: got y=%h sat=%b dz=%b want y=%h sat=%b dz=%b", r.y, r.sat, r.dz, e.y, e.sat, e.dz); end
            checks++;
            if (vcyc - icyc !== LAT) begin errors++; $display("FAIL ignore_lat: got %0d want %0d", vcyc - icyc, LAT); end
        end
        repeat (40) @(negedge clk);
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL ignore_extra: got %0d extra valid(s) want 0", obs_q.size()); end
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic test_back_to_back();
        res_t r1, r2, e;
        int   icyc, v1, v2, n;
        bit   g1, g2;
        @(negedge clk);
        bus.A     = 16'h0400;
        bus.B     = 16'h0C00;
        bus.start = 1'b1;
        icyc      = cyc;
        exp_q.push_back(res_t'{16'h0155, 1'b0, 1'b0});
        @(negedge clk);
        bus.A = 16'hFC00;
        exp_q.push_back(res_t'{16'hFEAB, 1'b0, 1'b0});
        n = 0;
        while (bus.valid !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.start = 1'b0;
        collect(r1, v1, g1);
        collect(r2, v2, g2);
        e = exp_q.pop_front();
        checks++;
        if (!g1) begin errors++; $display("FAIL b2b_first_timeout: no valid within %0d cycles", BUDGET); end
        else begin
            if (r1 !== e) begin errors++; $display("FAIL b2b_first: got y=%h sat=%b dz=%b want y=%h sat=%b dz=%b", r1.y, r1.sat, r1.dz, e.y, e.sat, e.dz); end
            checks++;
            if (v1 - icyc !== LAT) begin errors++; $display("FAIL b2b_first_lat: got %0d want %0d", v1 - icyc, LAT); end
        end
        e = exp_q.pop_front();
        checks++;
        if (!g2) begin errors++; $display("FAIL b2b_second_timeout: no valid within %0d cycles", BUDGET); end
        else begin
            if (r2 !== e) begin errors++; $display("FAIL b2b_second: got y=%h sat=%b dz=%b want y=%h sat=%b dz=%b", r2.y, r2.sat, r2.dz, e.y, e.sat, e.dz); end
            checks++;
            if (v2 - v1 !== LAT) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", v2 - v1, LAT); end
        end
    endtask

    task automatic test_reset_mid();
        res_t r, e;
        int   icyc, vcyc;
        bit   got;
        issue(16'h0C00, 16'h0800, icyc);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.Y !== '0) begin errors++; $display("FAIL midreset_y: got %h want 0", bus.Y); end
        checks++;
        if ({bus.busy, bus.valid, bus.sat, bus.dz} !== 4'b0000) begin
            errors++; $display("FAIL midreset_flags: got busy=%b valid=%b sat=%b dz=%b want all 0", bus.busy, bus.valid, bus.sat, bus.dz);
        end
        repeat (2) @(negedge clk);
        // Release and request on the same cycle: the first edge must take it
        rst_n     = 1'b1;
        bus.A     = 16'h0400;
        bus.B     = 16'h0C00;
        bus.start = 1'b1;
        icyc      = cyc;
        exp_q.push_back(res_t'{16'h0155, 1'b0, 1'b0});
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 16'h7FFF;
        bus.B     = 16'h0001;
        collect(r, vcyc, got);
        e = exp_q.pop_front();
        checks++;
        if (!got) begin errors++; $display("FAIL postreset_timeout: no valid within %0d cycles", BUDGET); end
        else begin
            if (r !== e) begin errors++; $display("FAIL postreset: got y=%h sat=%b dz=%b want y=%h sat=%b dz=%b", r.y, r.sat, r.dz, e.y, e.sat, e.dz); end
            checks++;
            if (vcyc - icyc !== LAT) begin errors++; $display("FAIL postreset_lat: got %0d want %0d", vcyc - icyc, LAT); end
        end
        repeat (40) @(negedge clk);
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL postreset_extra: got %0d extra valid(s) want 0", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_div_zero();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
